// File: rtl/rgb_led_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_scheduler
// Brief    : Round-robin sharing of one active-low RGB LED between requesters,
//            with timed grants, PWM brightness and a blank gap between grants.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_led_scheduler #(
    parameter int REQ_COUNT  = 3,
    parameter int PWM_WIDTH  = 8,
    parameter int PRESCALE   = 2**20,
    parameter int HOLD_TICKS = 16,
    parameter int GAP_CYCLES = 1024
) (
    input  logic                           clock,
    input  logic                           i_reset,
    input  logic [REQ_COUNT-1:0]           i_req,
    input  logic [3*REQ_COUNT-1:0]         i_colour,
    input  logic [PWM_WIDTH*REQ_COUNT-1:0] i_duty,
    output logic [REQ_COUNT-1:0]           o_grant,
    output logic [REQ_COUNT-1:0]           o_done,
    output logic                           o_busy,
    output logic                           LED_R,
    output logic                           LED_G,
    output logic                           LED_B
);

    localparam int PTR_W  = $clog2(REQ_COUNT + 1);
    localparam int PRE_W  = $clog2(PRESCALE + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SHOW = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;
    // With no gap configured, a finished or aborted grant returns straight to IDLE.
    localparam logic [1:0] c_AFTER = (GAP_CYCLES > 0) ? c_GAP : c_IDLE;

    localparam logic [PTR_W-1:0]  c_PTR_MAX   = PTR_W'(REQ_COUNT - 1);
    localparam logic [PRE_W-1:0]  c_PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [GAP_W-1:0]  c_GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [2:0]           r_colour;
    logic [PWM_WIDTH-1:0] r_duty;
    logic [PRE_W-1:0]     r_pre;
    logic [HOLD_W-1:0]    r_hold;
    logic [GAP_W-1:0]     r_gap;
    logic [PWM_WIDTH-1:0] r_pwm;
    logic [2:0]           r_led;
    logic [REQ_COUNT-1:0] r_done;

    logic                 w_found;
    logic [PTR_W-1:0]     w_pick;
    logic [PTR_W-1:0]     w_pick_nxt;
    logic [2:0]           w_pick_colour;
    logic [PWM_WIDTH-1:0] w_pick_duty;
    logic                 w_owner_req;
    logic                 w_last_tick;
    logic [REQ_COUNT-1:0] w_grant;
    logic                 w_busy;
    logic [2:0]           w_lit;

    // Round robin: first pass covers indices at/above the pointer, second pass wraps.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (!w_found && i_req[k] && (PTR_W'(k) >= r_ptr)) begin
                w_found = 1'b1;
                w_pick  = PTR_W'(k);
            end
        end
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (!w_found && i_req[k]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'(k);
            end
        end
    end

    always_comb begin
        w_pick_colour = '0;
        w_pick_duty   = '0;
        w_owner_req   = 1'b0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (w_pick == PTR_W'(k)) begin
                w_pick_colour = i_colour[3*k +: 3];
                w_pick_duty   = i_duty[PWM_WIDTH*k +: PWM_WIDTH];
            end
            if (r_owner == PTR_W'(k)) begin
                w_owner_req = i_req[k];
            end
        end
    end

    assign w_pick_nxt  = (w_pick == c_PTR_MAX) ? '0 : w_pick + 1'b1;
    assign w_last_tick = (r_pre == c_PRE_LAST) && (r_hold == c_HOLD_LAST);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort takes priority: a dropped request never produces a done pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_SHOW;
                end
            end
            c_SHOW: begin
                if (!w_owner_req || w_last_tick) begin
                    w_state_nxt = c_AFTER;
                end
            end
            c_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_grant = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if ((r_state == c_SHOW) && (r_owner == PTR_W'(k))) begin
                w_grant[k] = 1'b1;
            end
        end
        w_busy = (r_state != c_IDLE);
        w_lit  = r_colour & {3{(r_state == c_SHOW) && (r_pwm < r_duty)}};
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_colour <= '0;
            r_duty   <= '0;
            r_pre    <= '0;
            r_hold   <= '0;
            r_gap    <= '0;
            r_done   <= '0;
        end else begin
            r_done <= '0;
            r_gap  <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_owner  <= w_pick;
                        r_ptr    <= w_pick_nxt;
                        r_colour <= w_pick_colour;
                        r_duty   <= w_pick_duty;
                        r_pre    <= '0;
                        r_hold   <= '0;
                    end
                end
                c_SHOW: begin
                    if (r_pre == c_PRE_LAST) begin
                        r_pre  <= '0;
                        r_hold <= r_hold + 1'b1;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                    if (w_owner_req && w_last_tick) begin
                        r_done <= w_grant;
                    end
                end
                c_GAP: begin
                    r_gap <= r_gap + 1'b1;
                end
                default: begin
                    r_gap <= '0;
                end
            endcase
        end
    end

    // Free-running PWM counter; the pins are a registered copy of the compare.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_pwm <= '0;
            r_led <= 3'b111;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            r_led <= ~w_lit;
        end
    end

    assign o_grant = w_grant;
    assign o_done  = r_done;
    assign o_busy  = w_busy;
    assign LED_R   = r_led[2];
    assign LED_G   = r_led[1];
    assign LED_B   = r_led[0];

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rgb_led_scheduler
// Brief    : Self-checking bench for rgb_led_scheduler (vectors, directed
//            sequences and randomized traffic against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_led_scheduler;

    localparam int R    = 3;
    localparam int PW   = 4;
    localparam int PRE  = 4;
    localparam int HOLD = 3;
    localparam int GAP  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [R-1:0]    req;
    logic [3*R-1:0]  colour;
    logic [PW*R-1:0] duty;
    logic [R-1:0]    o_grant;
    logic [R-1:0]    o_done;
    logic            o_busy;
    logic            LED_R;
    logic            LED_G;
    logic            LED_B;

    always #5 clk = ~clk;

    rgb_led_scheduler #(
        .REQ_COUNT (R),
        .PWM_WIDTH (PW),
        .PRESCALE  (PRE),
        .HOLD_TICKS(HOLD),
        .GAP_CYCLES(GAP)
    ) dut (
        .clock   (clk),
        .i_reset (rst),
        .i_req   (req),
        .i_colour(colour),
        .i_duty  (duty),
        .o_grant (o_grant),
        .o_done  (o_done),
        .o_busy  (o_busy),
        .LED_R   (LED_R),
        .LED_G   (LED_G),
        .LED_B   (LED_B)
    );

    int ntests = 0;
    int nfail  = 0;

    // Behavioural model: mode 0=idle 1=show 2=gap, grant length as a countdown.
    int           m_mode = 0;
    int           m_owner = 0;
    int           m_ptr = 0;
    int           m_show_left = 0;
    int           m_gap_left = 0;
    int           m_pwm = 0;
    logic [2:0]   m_col = '0;
    logic [PW-1:0] m_duty = '0;
    logic [2:0]   m_led = 3'b111;
    logic [R-1:0] m_done = '0;

    int           cnt_grant[R];
    int           cnt_done[R];
    int           cnt_busy;
    int           cnt_low[3];
    int           order[$];
    logic [R-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [2:0] led_n;
        int k;
        for (int c = 0; c < 3; c++)
            led_n[c] = !(m_mode == 1 && m_col[c] && (m_pwm < int'(m_duty)));
        if (rst) begin
            m_mode = 0; m_ptr = 0; m_pwm = 0; m_owner = 0;
            m_led = 3'b111; m_done = '0;
            return;
        end
        m_led  = led_n;
        m_pwm  = (m_pwm + 1) % (1 << PW);
        m_done = '0;
        case (m_mode)
            0: begin
                for (int i = 0; i < R; i++) begin
                    k = (m_ptr + i) % R;
                    if (m_mode == 0 && req[k]) begin
                        m_owner = k;
                        m_ptr = (k + 1) % R;
                        m_show_left = HOLD * PRE;
                        m_col = colour[3*k +: 3];
                        m_duty = duty[PW*k +: PW];
                        m_mode = 1;
                    end
                end
            end
            1: begin
                if (!req[m_owner]) begin
                    m_mode = (GAP > 0) ? 2 : 0;
                    m_gap_left = GAP;
                end else begin
                    m_show_left--;
                    if (m_show_left == 0) begin
                        m_done[m_owner] = 1'b1;
                        m_mode = (GAP > 0) ? 2 : 0;
                        m_gap_left = GAP;
                    end
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic clear_stats();
        for (int k = 0; k < R; k++) begin cnt_grant[k] = 0; cnt_done[k] = 0; end
        for (int c = 0; c < 3; c++) cnt_low[c] = 0;
        cnt_busy = 0;
        order.delete();
    endtask

    task automatic tick();
        logic [R-1:0] eg;
        logic [2:0]   leds;
        @(posedge clk);
        model_step();
        #1;
        eg = '0;
        if (m_mode == 1) eg[m_owner] = 1'b1;
        leds = {LED_R, LED_G, LED_B};
        check("model", {o_grant, o_done, o_busy, leds}, {eg, m_done, (m_mode != 0), m_led});
        for (int k = 0; k < R; k++) begin
            if (o_grant[k]) cnt_grant[k]++;
            if (o_done[k]) cnt_done[k]++;
            if (o_grant[k] && !prev_grant[k]) order.push_back(k);
        end
        if (o_busy) cnt_busy++;
        for (int c = 0; c < 3; c++) if (!leds[c]) cnt_low[c]++;
        prev_grant = o_grant;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string name, input logic [R-1:0] g, input int bound);
        int n = 0;
        while (o_grant !== g && n < bound) begin tick(); n++; end
        check(name, o_grant, g);
    endtask

    task automatic drain();
        req = '0;
        for (int i = 0; i < 20; i++) tick();
    endtask

    typedef struct {
        logic         rst;
        logic [R-1:0] req;
        logic [R-1:0] e_grant;
        logic         e_busy;
        logic [2:0]   e_led;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int gcount;
        rst = 1'b1; req = '0; colour = '0; duty = '0;
        vecs[0] = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b111};
        vecs[1] = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b111};
        vecs[2] = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b111};
        vecs[3] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b111};
        vecs[4] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b111};
        vecs[5] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b011};
        vecs[6] = '{1'b0, 3'b001, 3'b001, 1'b1, 3'b011};

        // Reset, then requester 0 red at duty 15 for one full grant.
        colour = 9'b000_000_100;
        duty   = 12'h00F;
        clear_stats();
        for (int i = 0; i < 7; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            tick();
            check("vec_grant", o_grant, vecs[i].e_grant);
            check("vec_busy", o_busy, vecs[i].e_busy);
            check("vec_led", {LED_R, LED_G, LED_B}, vecs[i].e_led);
            check("vec_done", o_done, 3'b000);
        end
        n = 0;
        while (!o_done[0] && n < 40) begin tick(); n++; end
        check("single_done_seen", o_done, 3'b001);
        req = '0;
        for (int i = 0; i < 5; i++) tick();
        check("single_grant_len", cnt_grant[0], 12);
        check("single_done_cnt", cnt_done[0], 1);
        check("single_busy_len", cnt_busy, 14);
        check("single_red_low", cnt_low[2], 12);
        check("single_gb_low", cnt_low[1] + cnt_low[0], 0);

        // All three held: strict round-robin order from pointer 0.
        do_reset();
        colour = 9'b001_010_100;
        duty   = 12'h888;
        req    = 3'b111;
        clear_stats();
        n = 0;
        while (order.size() < 4 && n < 200) begin tick(); n++; end
        check("rr_count", order.size(), 4);
        if (order.size() >= 4) begin
            check("rr_order0", order[0], 0);
            check("rr_order1", order[1], 1);
            check("rr_order2", order[2], 2);
            check("rr_order3", order[3], 0);
        end
        check("rr_dones", cnt_done[0] + cnt_done[1] + cnt_done[2], 3);
        drain();

        // Requester 1 aborts five cycles into its grant.
        do_reset();
        req = 3'b010;
        clear_stats();
        wait_grant("abort_first", 3'b010, 10);
        for (int i = 0; i < 4; i++) tick();
        req = 3'b101;
        tick();
        check("abort_grant_off", o_grant, 3'b000);
        check("abort_no_done", o_done, 3'b000);
        wait_grant("abort_next", 3'b100, 20);
        check("abort_len", cnt_grant[1], 5);
        check("abort_done_cnt", cnt_done[1], 0);
        drain();

        // Duty 0 keeps every LED dark; a duty change mid-grant is ignored.
        do_reset();
        colour = 9'b000_000_111;
        duty   = 12'h000;
        req    = 3'b001;
        clear_stats();
        gcount = 0;
        n = 0;
        while (!o_done[0] && n < 40) begin
            tick(); n++;
            if (o_grant[0]) gcount++;
            if (gcount == 6) duty = 12'h00F;
        end
        req = '0;
        for (int i = 0; i < 3; i++) tick();
        check("duty0_done", cnt_done[0], 1);
        check("duty0_dark", cnt_low[0] + cnt_low[1] + cnt_low[2], 0);

        // Reset in the middle of a grant returns everything, including the pointer.
        do_reset();
        colour = 9'b100_100_100;
        duty   = 12'hFFF;
        req    = 3'b010;
        wait_grant("rstmid_first", 3'b010, 10);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        check("rstmid_outputs", {o_grant, o_done, o_busy, LED_R, LED_G, LED_B}, 10'b000_000_0_111);
        rst = 1'b0;
        req = 3'b111;
        tick();
        check("rstmid_ptr", o_grant, 3'b001);
        drain();

        // Randomized traffic compared cycle by cycle with the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(399) == 0);
            for (int k = 0; k < R; k++)
                if ($urandom_range(15) == 0) req[k] = ~req[k];
            if ($urandom_range(7) == 0) colour = 9'($urandom);
            if ($urandom_range(7) == 0) duty = 12'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
